// File: rtl/conv2d_window_gen_pkg.sv
// ----------------------------------------------------------------------------
// conv2d_window_gen_pkg : shared conv2d widths and kernel geometry
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv2d_window_gen_pkg;

  localparam int   BIT_DATA     = 8;
  localparam int   CONV2D_KDIM  = 3;
  localparam int   CONV2D_KSIZE = CONV2D_KDIM * CONV2D_KDIM;
  localparam logic OFF          = 1'b0;

endpackage

`default_nettype wire

// File: rtl/conv2d_window_gen_line_buffer.sv
// ----------------------------------------------------------------------------
// line_buffer : one image row of pixels, write-enabled, read at write address
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module line_buffer
  import conv2d_window_gen_pkg::*;
#(
  parameter int DEPTH = 28
) (
  input  logic                     clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [BIT_DATA-1:0]      i_wdata,
  output logic [BIT_DATA-1:0]      o_rdata
);

  logic [BIT_DATA-1:0] r_mem [DEPTH];

  // Contents are deliberately unreset; stale rows are never emitted.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/conv2d_window_gen.sv
// ----------------------------------------------------------------------------
// conv2d_window_gen : raster stream to packed 3x3 windows for the conv2d kernel
// Optional win_last output enabled by CONV2D_WIN_LAST_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv2d_window_gen
  import conv2d_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [BIT_DATA-1:0]              in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [BIT_DATA*CONV2D_KSIZE-1:0] win_x,
  output logic                             win_valid,
  input  logic                             win_ready
`ifdef CONV2D_WIN_LAST_EN
  ,
  output logic                             win_last
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic                r_win_valid;
  logic [BIT_DATA-1:0] r_win [CONV2D_KDIM][CONV2D_KDIM];

  logic                w_accept;
  logic                w_emit;
  logic                w_col_wrap;
  logic                w_row_wrap;
  logic [BIT_DATA-1:0] w_top;
  logic [BIT_DATA-1:0] w_mid;

  assign in_ready   = !r_win_valid || win_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_col_wrap = (r_col == c_col_last);
  assign w_row_wrap = (r_row == c_row_last);
  // col >= 2 keeps every window inside a single row
  assign w_emit     = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

  // lb0 holds the previous row, lb1 the one before; lb0 spills into lb1
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clock   (clock),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (in_data),
    .o_rdata (w_mid)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clock   (clock),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_mid),
    .o_rdata (w_top)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < CONV2D_KDIM; r++) begin
        for (int c = 0; c < CONV2D_KDIM; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < CONV2D_KDIM; r++) begin
        for (int c = 0; c < CONV2D_KDIM - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
      end
      r_win[0][CONV2D_KDIM-1] <= w_top;
      r_win[1][CONV2D_KDIM-1] <= w_mid;
      r_win[2][CONV2D_KDIM-1] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_valid <= OFF;
    end else if (w_emit) begin
      r_win_valid <= 1'b1;
    end else if (win_ready) begin
      r_win_valid <= OFF;
    end
  end

  assign win_valid = r_win_valid;

  // Window array doubles as the output register: it only moves on accept,
  // and accept is blocked while a window is stalled.
  for (genvar gr = 0; gr < CONV2D_KDIM; gr++) begin : g_row
    for (genvar gc = 0; gc < CONV2D_KDIM; gc++) begin : g_col
      assign win_x[BIT_DATA*(gr*CONV2D_KDIM+gc) +: BIT_DATA] = r_win[gr][gc];
    end
  end

`ifdef CONV2D_WIN_LAST_EN
  logic r_win_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_last <= OFF;
    end else if (w_emit) begin
      r_win_last <= w_col_wrap && w_row_wrap;
    end else if (win_ready) begin
      r_win_last <= OFF;
    end
  end

  assign win_last = r_win_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv2d_window_gen.sv
// ----------------------------------------------------------------------------
// tb_conv2d_window_gen : scoreboard bench for conv2d_window_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_conv2d_window_gen;
  import conv2d_window_gen_pkg::*;

`ifdef CONV2D_WIN_LAST_EN
  localparam int W = 5;
  localparam int H = 3;
  localparam int STALL_K = 3;
`else
  localparam int W = 4;
  localparam int H = 4;
  localparam int STALL_K = 1;
`endif
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int XW   = BIT_DATA * CONV2D_KSIZE;

  logic                clock;
  logic                reset;
  logic [BIT_DATA-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [XW-1:0]       win_x;
  logic                win_valid;
  logic                win_ready;
`ifdef CONV2D_WIN_LAST_EN
  logic                win_last;
`endif

  conv2d_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_x     (win_x),
    .win_valid (win_valid),
    .win_ready (win_ready)
`ifdef CONV2D_WIN_LAST_EN
    ,
    .win_last  (win_last)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XW-1:0] x;
    bit            last;
  } exp_t;

  exp_t                exp_q[$];
  logic [BIT_DATA-1:0] img [H][W];
  int                  m_row = 0;
  int                  m_col = 0;
  int                  checks = 0;
  int                  failures = 0;
  int                  frame_pops = 0;
  bit                  rdy_rand = 0;
  bit                  gap_en = 0;

  task automatic check(input string name, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame image array plus the window rule, kept in step
  // with the handshake observed at the negedge before each clock edge.
  always @(posedge reset) begin
    m_row = 0;
    m_col = 0;
    exp_q.delete();
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("win_valid", XW'(win_valid), XW'(exp_q.size() != 0));
      check("in_ready", XW'(in_ready), XW'((exp_q.size() == 0) || win_ready));
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", XW'(1), XW'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("win_x", win_x, e.x);
`ifdef CONV2D_WIN_LAST_EN
          check("win_last", XW'(win_last), XW'(e.last));
`endif
          frame_pops++;
        end
      end
      if (in_valid && in_ready) begin
        img[m_row][m_col] = in_data;
        if (m_row >= 2 && m_col >= 2) begin
          exp_t e;
          e.x = '0;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              e.x[BIT_DATA*(rr*3+cc) +: BIT_DATA] = img[m_row-2+rr][m_col-2+cc];
          e.last = (m_row == H - 1) && (m_col == W - 1);
          exp_q.push_back(e);
        end
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rdy_rand) win_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_pixel(input logic [BIT_DATA-1:0] d);
    bit acc = 0;
    int budget = 0;
    in_data = d;
    while (!acc) begin
      in_valid = !(gap_en && ($urandom_range(0, 3) == 0));
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      budget++;
      if (budget > 300) begin
        check("accept_timeout", XW'(0), XW'(1));
        return;
      end
    end
  endtask

  task automatic send_frame(input int mode, input int base, input int npix);
    logic [BIT_DATA-1:0] v;
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       v = BIT_DATA'(base + i);
        1:       v = BIT_DATA'($urandom);
        default: case (i % 4)
                   0: v = 8'h80;
                   1: v = 8'hFF;
                   2: v = 8'h7F;
                   default: v = BIT_DATA'(i);
                 endcase
      endcase
      send_pixel(v);
    end
  endtask

  task automatic drain();
    int budget = 0;
    in_valid = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clock);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) check("drain_timeout", XW'(exp_q.size()), XW'(0));
    rdy_rand = 0;
    win_ready = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic stall_on(input int k);
    int budget = 0;
    logic [XW-1:0] snap;
    logic snap_last;
    while (!(win_valid && frame_pops == k - 1)) begin
      @(posedge clock);
      #1;
      budget++;
      if (budget > 500) begin
        check("stall_wait_timeout", XW'(0), XW'(1));
        return;
      end
    end
    win_ready = 0;
    snap = win_x;
`ifdef CONV2D_WIN_LAST_EN
    snap_last = win_last;
    check("stall_last_is_final", XW'(snap_last), XW'(k == NWIN));
`else
    snap_last = 1'b0;
`endif
    repeat (5) begin
      @(negedge clock);
      check("stall_in_ready", XW'(in_ready), XW'(0));
      check("stall_win_x_held", win_x, snap);
`ifdef CONV2D_WIN_LAST_EN
      check("stall_win_last_held", XW'(win_last), XW'(snap_last));
`endif
      @(posedge clock);
      #1;
    end
    win_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    #1;
    check("reset_win_valid", XW'(win_valid), XW'(0));
    check("reset_in_ready", XW'(in_ready), XW'(1));
    check("reset_win_x", win_x, XW'(0));
`ifdef CONV2D_WIN_LAST_EN
    check("reset_win_last", XW'(win_last), XW'(0));
`endif
    @(posedge clock);
    #1;
    reset = 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 0;
    reset = 1;
    in_valid = 0;
    in_data = '0;
    win_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    frame_pops = 0;
    send_frame(0, 1, NPIX);
    drain();
    check("count_basic", XW'(frame_pops), XW'(NWIN));

    frame_pops = 0;
    fork
      send_frame(0, 1, NPIX);
      stall_on(STALL_K);
    join
    drain();
    check("count_stall", XW'(frame_pops), XW'(NWIN));

    frame_pops = 0;
    send_frame(0, 1, NPIX);
    send_frame(0, 101, NPIX);
    drain();
    check("count_back_to_back", XW'(frame_pops), XW'(2 * NWIN));

    send_frame(0, 1, 7);
    do_reset();
    frame_pops = 0;
    send_frame(0, 1, NPIX);
    drain();
    check("count_after_reset", XW'(frame_pops), XW'(NWIN));

    frame_pops = 0;
    send_frame(2, 0, NPIX);
    drain();
    check("count_negative", XW'(frame_pops), XW'(NWIN));

    frame_pops = 0;
    rdy_rand = 1;
    gap_en = 1;
    repeat (12) send_frame(1, 0, NPIX);
    gap_en = 0;
    drain();
    check("count_random", XW'(frame_pops), XW'(12 * NWIN));

    check("queue_empty", XW'(exp_q.size()), XW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
